fsm_ctx_scheduler: RTL
======================

Name: fsm_ctx_scheduler

Overview:
Time-multiplexes one 4-state, symbol-driven Mealy FSM core among NUM_REQ requesters. Each requester owns a private 2-bit state context. A round-robin arbiter selects one requester symbol per cycle, steps that requester's context, and returns the output bit and new state through a registered response port with backpressure. Sits between symbol producers and the downstream consumers of the FSM decision bit.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, max(1,$clog2(NUM_REQ)), width of requester index (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester symbol valid
req_sym  in  2*NUM_REQ  per-requester 2-bit symbol; requester i uses bits [2i+1:2i]
req_ready  out  NUM_REQ  one-hot accept; combinational
ctx_clear  in  NUM_REQ  synchronous per-requester context clear to S0
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_id  out  ID_W  requester index of the response
rsp_bit  out  1  FSM output bit for the stepped symbol
rsp_state  out  2  context state after the step

Behaviour:
- Reset (async, active-high): every ctx = S0 (2'b00); rr_ptr = 0; rsp_valid = 0; rsp_id = 0; rsp_bit = 0; rsp_state = 0.
- FSM step function, written as next state per symbol 0/1/2/3, then output:
  - S0 -> S0/S1/S2/S3, out 1
  - S1 -> S0/S3/S1/S3, out 0
  - S2 -> S1/S3/S2/S0, out 1
  - S3 -> S1/S0/S0/S3, out 0
  - The output depends only on the pre-step state.
- Accept condition: accept = !rsp_valid || rsp_ready.
- Arbitration: the grant g is the first i with req_valid[i]=1, searching upward from rr_ptr with wrap at NUM_REQ-1 -> 0.
  - req_ready[g] = accept. All other req_ready bits are 0.
  - If no req_valid is set, req_ready = 0.
- Handshake on req_valid[g] && req_ready[g]:
  - ctx[g] <= next(ctx[g], sym_g).
  - rsp_valid <= 1, rsp_id <= g, rsp_bit <= out(ctx[g]), rsp_state <= next(ctx[g], sym_g).
  - rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1.
- Latency: the response is registered 1 cycle after the handshake. Throughput is 1 symbol/cycle when rsp_ready is held high.
- Response drain: if rsp_valid && rsp_ready and there is no new handshake, rsp_valid <= 0 and the other rsp fields hold their values.
- Backpressure: if rsp_valid && !rsp_ready, all rsp_* outputs hold stable, req_ready = 0, and ctx and rr_ptr are unchanged.
- ctx_clear[i]: ctx[i] <= S0 on the next edge.
  - If it collides with a handshake for i in the same cycle, the clear wins for ctx[i].
  - The response is still issued with the computed rsp_bit and rsp_state.
- Requesters must hold req_valid and req_sym stable until accepted. The block does not check this.
- Reset mid-operation discards any pending response immediately. No partial step is retained.
- Illegal ctx encodings are impossible: all 4 codes are states.

Optional Feature:
FSM_STATS_EN
- Defined: adds output port stat_ones (16 bits). It counts handshakes whose computed out bit is 1.
  - Increments on the same edge the response is registered.
  - Saturates at 16'hFFFF.
  - Reset value 0.
  - Not affected by ctx_clear.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Single requester:
  - Stimulus: after reset, requester 0 sends syms 1, 3, 0 with rsp_ready=1.
  - Required: responses (id0, bit1, state01), (id0, bit0, state11), (id0, bit0, state01), each 1 cycle after its handshake.
- Round-robin:
  - Stimulus: all 4 req_valid held high, rsp_ready=1.
  - Required: grant order 0, 1, 2, 3, 0, 1. req_ready one-hot every cycle. rsp_id follows the same order 1 cycle later.
- Backpressure:
  - Stimulus: rsp_valid=1 with rsp_ready=0 for 3 cycles.
  - Required: rsp_* stable, req_ready=0, no context change. Release yields one drain plus the next grant on the same edge.
- Clear collision:
  - Stimulus: requester 1 stepped to S2 (sym 2). Next, sym 0 together with ctx_clear[1]=1.
  - Required: response bit1, state01. A following sym 1 returns bit1, state01 (the context restarted at S0).
- Async reset mid-stream:
  - Stimulus: reset asserted between edges while rsp_valid=1.
  - Required: rsp_valid=0 immediately, all contexts S0, rr_ptr=0.
- With FSM_STATS_EN:
  - Stimulus: 5 steps from S0 with syms 2, 2, 0, 1, 3 (outputs 1, 1, 1, 0, 0).
  - Required: stat_ones=3.
  - Stimulus: preload near 16'hFFFF.
  - Required: stat_ones saturates and does not wrap.

Source files
------------

// File: rtl/fsm_ctx_scheduler.sv
// fsm_ctx_scheduler: round-robin time-multiplexed 4-state Mealy FSM with per-requester contexts; optional FSM_STATS_EN adds stat_ones
module fsm_ctx_scheduler #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_sym,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   ctx_clear,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_bit,
  output logic [1:0]           rsp_state
`ifdef FSM_STATS_EN
  ,
  output logic [15:0]          stat_ones
`endif
);
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;
  state_t ctx [NUM_REQ];
  state_t ctx_g, nxt;
  logic [ID_W-1:0] rr_ptr, g, idx;
  logic [ID_W:0] sum;
  logic [1:0] sym_g;
  logic found, accept, hs, out_bit;
  assign accept = !rsp_valid || rsp_ready;
  assign hs = found && accept;
  assign sym_g = req_sym[{g, 1'b0} +: 2];
  assign ctx_g = ctx[g];
  assign out_bit = ~ctx_g[0];
  // round-robin search for the first valid requester at or after rr_ptr
  always_comb begin
    found = 1'b0;
    g = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      sum = (sum >= (ID_W+1)'(NUM_REQ)) ? sum - (ID_W+1)'(NUM_REQ) : sum;
      idx = sum[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  // one-hot accept for the granted requester only
  always_comb begin
    req_ready = '0;
    if (hs) req_ready[g] = 1'b1;
  end
  // shared FSM core: next state of the granted context for its symbol
  always_comb begin
    nxt = S0;
    case (ctx_g)
      S0: nxt = state_t'(sym_g);
      S1: nxt = sym_g[0] ? S3 : (sym_g[1] ? S1 : S0);
      S2: nxt = (sym_g == 2'd0) ? S1 : (sym_g == 2'd1) ? S3 : (sym_g == 2'd2) ? S2 : S0;
      S3: nxt = (sym_g == 2'd0) ? S1 : (sym_g == 2'd3) ? S3 : S0;
    endcase
  end
  // per-requester contexts; a clear overrides a same-cycle step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) ctx[i] <= S0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (ctx_clear[i]) ctx[i] <= S0;
        else if (hs && g == ID_W'(i)) ctx[i] <= nxt;
    end
  end
  // arbitration pointer moves past the winner on each handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= '0;
    else if (hs) rr_ptr <= (g == ID_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
  end
  // registered response; fields hold while stalled or after draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bit   <= 1'b0;
      rsp_state <= 2'd0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_id    <= g;
      rsp_bit   <= out_bit;
      rsp_state <= nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef FSM_STATS_EN
  // saturating count of handshakes whose output bit is 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stat_ones <= '0;
    else if (hs && out_bit && stat_ones != 16'hFFFF) stat_ones <= stat_ones + 16'd1;
  end
`endif
endmodule
